// File: rtl/cmv_seq_pkg.sv
// Shared types and constants for the CMV300 SPI init sequencer.
package cmv_seq_pkg;

  localparam int CMV_ADDR_W = 7;
  localparam int CMV_DATA_W = 8;

  localparam logic SPI_MODE_READ  = 1'b0;
  localparam logic SPI_MODE_WRITE = 1'b1;

  typedef enum logic [3:0] {
    IDLE,
    WAIT_RST,
    WR_ISSUE,
    WR_BUSY,
    WR_WAIT,
    RD_ISSUE,
    RD_BUSY,
    RD_WAIT,
    CHECK,
    PC_ISSUE,
    PC_BUSY,
    PC_WAIT,
    ERROR
  } seq_state_t;

  function automatic logic is_issue(seq_state_t s);
    return (s == WR_ISSUE) || (s == RD_ISSUE) || (s == PC_ISSUE);
  endfunction

endpackage

// File: rtl/cmv_spi_init_seq_if.sv
// Command/response bus between the sequencer and the CMV300 SPI engine.
interface cmv_spi_init_seq_if;
  import cmv_seq_pkg::*;

  logic                  spi_start;
  logic                  spi_mode;
  logic [CMV_ADDR_W-1:0] spi_addr;
  logic [CMV_DATA_W-1:0] spi_wdata;
  logic                  spi_ready;
  logic [CMV_DATA_W-1:0] spi_rdata;

  modport master (
    output spi_start, spi_mode, spi_addr, spi_wdata,
    input  spi_ready, spi_rdata
  );

  modport slave (
    input  spi_start, spi_mode, spi_addr, spi_wdata,
    output spi_ready, spi_rdata
  );

endinterface

// File: rtl/cmv_pc_req_latch.sv
// One-deep holding register for a PC register access; new requests are
// dropped while one is pending, and the slot frees when the access is done.
module cmv_pc_req_latch
  import cmv_seq_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pc_req,
  input  logic                  pc_write,
  input  logic [CMV_ADDR_W-1:0] pc_addr,
  input  logic [CMV_DATA_W-1:0] pc_wdata,
  input  logic                  clear,
  output logic                  pc_pending,
  output logic                  req_write,
  output logic [CMV_ADDR_W-1:0] req_addr,
  output logic [CMV_DATA_W-1:0] req_wdata
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_pending <= 1'b0;
      req_write  <= 1'b0;
      req_addr   <= '0;
      req_wdata  <= '0;
    end else if (clear) begin
      pc_pending <= 1'b0;
    end else if (pc_req && !pc_pending) begin
      pc_pending <= 1'b1;
      req_write  <= pc_write;
      req_addr   <= pc_addr;
      req_wdata  <= pc_wdata;
    end
  end

endmodule

// File: rtl/cmv_spi_init_seq.sv
// Walks the sensor register table (write, read back, verify) and shares the
// SPI engine with single PC-issued accesses between sequences.
module cmv_spi_init_seq
  import cmv_seq_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = $clog2(NUM_REGS),
  parameter int RST_WAIT = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_start,
  output logic [IDX_W-1:0]      tbl_idx,
  input  logic [CMV_ADDR_W-1:0] tbl_addr,
  input  logic [CMV_DATA_W-1:0] tbl_data,
  input  logic                  pc_req,
  input  logic                  pc_write,
  input  logic [CMV_ADDR_W-1:0] pc_addr,
  input  logic [CMV_DATA_W-1:0] pc_wdata,
  output logic [CMV_DATA_W-1:0] pc_rdata,
  output logic                  pc_done,
  output logic                  pc_pending,
  cmv_spi_init_seq_if.master    spi,
  output logic                  init_busy,
  output logic                  init_done,
  output logic                  init_err,
  output logic [IDX_W-1:0]      err_idx
);

  localparam int CNT_W = (RST_WAIT > 1) ? $clog2(RST_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RST_WAIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  seq_state_t            state, next_state;
  logic [CNT_W-1:0]      wait_cnt;
  logic [CMV_DATA_W-1:0] rd_q;
  logic                  ret_err;
  logic                  start_seq, idx_inc, set_err, set_done, rd_cap, pc_fin;
  logic                  req_write;
  logic [CMV_ADDR_W-1:0] req_addr;
  logic [CMV_DATA_W-1:0] req_wdata;

  cmv_pc_req_latch u_pc_latch (
    .clk        (clk),
    .rst        (rst),
    .pc_req     (pc_req),
    .pc_write   (pc_write),
    .pc_addr    (pc_addr),
    .pc_wdata   (pc_wdata),
    .clear      (pc_fin),
    .pc_pending (pc_pending),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata)
  );

  // WAIT_RST also holds for spi_ready so a transfer cut off by reset can finish first.
  always_comb begin
    next_state = state;
    start_seq  = 1'b0;
    idx_inc    = 1'b0;
    set_err    = 1'b0;
    set_done   = 1'b0;
    rd_cap     = 1'b0;
    pc_fin     = 1'b0;
    case (state)
      IDLE, ERROR: begin
        if (init_start) begin
          start_seq  = 1'b1;
          next_state = WAIT_RST;
        end else if (pc_pending && spi.spi_ready) begin
          next_state = PC_ISSUE;
        end
      end
      WAIT_RST: if (wait_cnt == CNT_LAST && spi.spi_ready) next_state = WR_ISSUE;
      WR_ISSUE: next_state = WR_BUSY;
      WR_BUSY:  if (!spi.spi_ready) next_state = WR_WAIT;
      WR_WAIT:  if (spi.spi_ready) next_state = RD_ISSUE;
      RD_ISSUE: next_state = RD_BUSY;
      RD_BUSY:  if (!spi.spi_ready) next_state = RD_WAIT;
      RD_WAIT: begin
        if (spi.spi_ready) begin
          rd_cap     = 1'b1;
          next_state = CHECK;
        end
      end
      CHECK: begin
        if (rd_q != tbl_data) begin
          set_err    = 1'b1;
          next_state = ERROR;
        end else if (tbl_idx == LAST_IDX) begin
          set_done   = 1'b1;
          next_state = IDLE;
        end else begin
          idx_inc    = 1'b1;
          next_state = WR_ISSUE;
        end
      end
      PC_ISSUE: next_state = PC_BUSY;
      PC_BUSY:  if (!spi.spi_ready) next_state = PC_WAIT;
      PC_WAIT: begin
        if (spi.spi_ready) begin
          pc_fin     = 1'b1;
          next_state = ret_err ? ERROR : IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      tbl_idx       <= '0;
      rd_q          <= '0;
      ret_err       <= 1'b0;
      spi.spi_start <= 1'b0;
      pc_done       <= 1'b0;
      pc_rdata      <= '0;
      init_done     <= 1'b0;
      init_err      <= 1'b0;
      err_idx       <= '0;
    end else begin
      state         <= next_state;
      spi.spi_start <= is_issue(next_state);
      pc_done       <= pc_fin;
      if (pc_fin && !req_write) pc_rdata <= spi.spi_rdata;
      if ((state == IDLE || state == ERROR) && next_state == PC_ISSUE)
        ret_err <= (state == ERROR);
      if (start_seq) begin
        init_done <= 1'b0;
        init_err  <= 1'b0;
        tbl_idx   <= '0;
        wait_cnt  <= '0;
      end else if (state == WAIT_RST && wait_cnt != CNT_LAST) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
      if (idx_inc) tbl_idx <= tbl_idx + IDX_W'(1);
      if (rd_cap) rd_q <= spi.spi_rdata;
      if (set_err) begin
        init_err <= 1'b1;
        err_idx  <= tbl_idx;
      end
      if (set_done) init_done <= 1'b1;
    end
  end

  // Address/data/mode follow the state so they stay put for the whole transfer.
  always_comb begin
    spi.spi_mode  = SPI_MODE_READ;
    spi.spi_addr  = '0;
    spi.spi_wdata = '0;
    case (state)
      WR_ISSUE, WR_BUSY, WR_WAIT: begin
        spi.spi_mode  = SPI_MODE_WRITE;
        spi.spi_addr  = tbl_addr;
        spi.spi_wdata = tbl_data;
      end
      RD_ISSUE, RD_BUSY, RD_WAIT: spi.spi_addr = tbl_addr;
      PC_ISSUE, PC_BUSY, PC_WAIT: begin
        spi.spi_mode  = req_write;
        spi.spi_addr  = req_addr;
        spi.spi_wdata = req_wdata;
      end
      default: ;
    endcase
  end

  assign init_busy = (state == WAIT_RST) || (state == WR_ISSUE) || (state == WR_BUSY) ||
                     (state == WR_WAIT)  || (state == RD_ISSUE) || (state == RD_BUSY) ||
                     (state == RD_WAIT)  || (state == CHECK);

endmodule

// File: tb/tb_cmv_spi_init_seq.sv
// Directed bench: 3-entry table, behavioural SPI engine with a programmable busy time.
module tb_cmv_spi_init_seq;
  import cmv_seq_pkg::*;

  localparam int NUM_REGS = 3;
  localparam int IDX_W    = 2;
  localparam int RST_WAIT = 4;
  localparam logic [6:0] TBL_A [3] = '{7'h20, 7'h21, 7'h22};
  localparam logic [7:0] TBL_D [3] = '{8'hA5, 8'h3C, 8'h7E};

  logic clk = 1'b0;
  logic rst, init_start, pc_req, pc_write;
  logic [6:0] pc_addr, tbl_addr;
  logic [7:0] pc_wdata, tbl_data, pc_rdata;
  logic pc_done, pc_pending, init_busy, init_done, init_err;
  logic [IDX_W-1:0] tbl_idx, err_idx;
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  cmv_spi_init_seq_if sif ();

  cmv_spi_init_seq #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W), .RST_WAIT(RST_WAIT)) dut (
    .clk(clk), .rst(rst), .init_start(init_start), .tbl_idx(tbl_idx),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data), .pc_req(pc_req), .pc_write(pc_write),
    .pc_addr(pc_addr), .pc_wdata(pc_wdata), .pc_rdata(pc_rdata), .pc_done(pc_done),
    .pc_pending(pc_pending), .spi(sif), .init_busy(init_busy), .init_done(init_done),
    .init_err(init_err), .err_idx(err_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    tbl_addr = '0;
    tbl_data = '0;
    if (tbl_idx < 2'd3) begin
      tbl_addr = TBL_A[tbl_idx];
      tbl_data = TBL_D[tbl_idx];
    end
  end

  // Engine model: ready drops the cycle after start and returns eng_n cycles later.
  int eng_n = 5;
  int eng_cnt = 0;
  bit corrupt_en = 1'b0;
  logic [6:0] corrupt_addr = 7'h21;
  logic eng_ready = 1'b1;
  logic [7:0] eng_rdata = 8'h00;
  logic e_mode = 1'b0;
  logic [6:0] e_addr = '0;
  logic [7:0] e_wdata = '0;
  logic [7:0] mem [128];
  bit mem_ld = 1'b0;
  assign sif.spi_ready = eng_ready;
  assign sif.spi_rdata = eng_rdata;

  always @(posedge clk) begin
    if (!mem_ld) begin
      for (int i = 0; i < 128; i++) mem[i] <= 8'h00;
      mem[7'h10] <= 8'hC3;
      mem_ld <= 1'b1;
    end
    if (sif.spi_start) begin
      eng_ready <= 1'b0;
      eng_cnt   <= eng_n;
      e_mode    <= sif.spi_mode;
      e_addr    <= sif.spi_addr;
      e_wdata   <= sif.spi_wdata;
    end else if (eng_cnt == 1) begin
      eng_ready <= 1'b1;
      eng_cnt   <= 0;
      if (e_mode) mem[e_addr] <= e_wdata;
      else eng_rdata <= (corrupt_en && e_addr == corrupt_addr) ? (mem[e_addr] ^ 8'h01) : mem[e_addr];
    end else if (eng_cnt > 1) begin
      eng_cnt <= eng_cnt - 1;
    end
  end

  // Access log and pulse counters, sampled mid-cycle.
  int acc_n = 0, dbl_cnt = 0, pcdone_cnt = 0, rise_cyc = 0;
  logic acc_mode [128];
  logic [6:0] acc_addr [128];
  logic [7:0] acc_wdata [128];
  int acc_cyc [128];
  int acc_rise [128];
  bit prev_start = 1'b0, prev_ready = 1'b1;

  always @(negedge clk) begin
    if (sif.spi_ready && !prev_ready) rise_cyc = cyc;
    if (sif.spi_start && acc_n < 128) begin
      acc_mode[acc_n]  = sif.spi_mode;
      acc_addr[acc_n]  = sif.spi_addr;
      acc_wdata[acc_n] = sif.spi_wdata;
      acc_cyc[acc_n]   = cyc;
      acc_rise[acc_n]  = rise_cyc;
      acc_n++;
    end
    if (sif.spi_start && prev_start) dbl_cnt++;
    if (pc_done) pcdone_cnt++;
    prev_start = sif.spi_start;
    prev_ready = sif.spi_ready;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
  endtask

  task automatic wait_sig(input int which, input int limit, output bit ok, output int at);
    ok = 1'b0;
    at = 0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      case (which)
        0: ok = (init_done === 1'b1);
        1: ok = (init_err === 1'b1);
        2: ok = (pc_done === 1'b1);
        default: ok = (dut.state === RD_BUSY);
      endcase
      if (ok) at = cyc;
    end
  endtask

  task automatic test_reset();
    n_checks++; if (sif.spi_start !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_spi_start: got %b want 0", sif.spi_start); end
    n_checks++; if (init_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_busy: got %b want 0", init_busy); end
    n_checks++; if ({init_done, init_err} !== 2'b00) begin n_fail++; $display("[TB] FAIL rst_flags: got %b want 00", {init_done, init_err}); end
    n_checks++; if ({tbl_idx, err_idx} !== 4'h0) begin n_fail++; $display("[TB] FAIL rst_idx: got %h want 0", {tbl_idx, err_idx}); end
    n_checks++; if ({pc_done, pc_pending, pc_rdata} !== 10'h0) begin n_fail++; $display("[TB] FAIL rst_pc: got %h want 0", {pc_done, pc_pending, pc_rdata}); end
    n_checks++; if ({sif.spi_mode, sif.spi_addr, sif.spi_wdata} !== 16'h0) begin n_fail++; $display("[TB] FAIL rst_spi_bus: got %h want 0", {sif.spi_mode, sif.spi_addr, sif.spi_wdata}); end
  endtask

  task automatic test_sequence();
    int base, sc, at;
    bit ok;
    base = acc_n;
    sc = cyc;
    pulse_start();
    wait_sig(0, 400, ok, at);
    n_checks++; if (!ok) begin n_fail++; $display("[TB] FAIL seq_timeout: init_done got 0 want 1"); end
    n_checks++; if (acc_cyc[base] - sc !== RST_WAIT + 1) begin n_fail++; $display("[TB] FAIL seq_first_start: got %0d want %0d", acc_cyc[base] - sc, RST_WAIT + 1); end
    n_checks++; if (at - sc !== RST_WAIT + 1 + NUM_REGS * (2 * (eng_n + 2) + 1)) begin n_fail++; $display("[TB] FAIL seq_total_cycles: got %0d want %0d", at - sc, RST_WAIT + 1 + NUM_REGS * (2 * (eng_n + 2) + 1)); end
    n_checks++; if (acc_n - base !== 6) begin n_fail++; $display("[TB] FAIL seq_access_count: got %0d want 6", acc_n - base); end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (acc_mode[base+i] !== (i % 2 == 0) || acc_addr[base+i] !== TBL_A[i/2] ||
          (i % 2 == 0 && acc_wdata[base+i] !== TBL_D[i/2])) begin
        n_fail++;
        $display("[TB] FAIL seq_access_%0d: got mode %b addr %h data %h want mode %b addr %h data %h",
                 i, acc_mode[base+i], acc_addr[base+i], acc_wdata[base+i], (i % 2 == 0), TBL_A[i/2], TBL_D[i/2]);
      end
    end
    n_checks++; if ({init_err, init_busy} !== 2'b00) begin n_fail++; $display("[TB] FAIL seq_err_busy: got %b want 00", {init_err, init_busy}); end
  endtask

  task automatic test_pc_during_seq();
    int base, at, pat, pd0;
    bit ok;
    base = acc_n;
    pd0 = pcdone_cnt;
    pulse_start();
    tick(6);
    pc_req = 1'b1; pc_write = 1'b1; pc_addr = 7'h3A; pc_wdata = 8'h55;
    tick();
    pc_req = 1'b0;
    n_checks++; if (pc_pending !== 1'b1) begin n_fail++; $display("[TB] FAIL pcw_pending: got %b want 1", pc_pending); end
    wait_sig(0, 400, ok, at);
    n_checks++; if (!ok) begin n_fail++; $display("[TB] FAIL pcw_seq_timeout: init_done got 0 want 1"); end
    n_checks++; if (acc_n - base !== 6) begin n_fail++; $display("[TB] FAIL pcw_preempt: accesses before done got %0d want 6", acc_n - base); end
    wait_sig(2, 50, ok, pat);
    n_checks++; if (!ok) begin n_fail++; $display("[TB] FAIL pcw_done_timeout: pc_done got 0 want 1"); end
    n_checks++;
    if (acc_mode[base+6] !== 1'b1 || acc_addr[base+6] !== 7'h3A || acc_wdata[base+6] !== 8'h55) begin
      n_fail++;
      $display("[TB] FAIL pcw_access: got mode %b addr %h data %h want 1 3a 55", acc_mode[base+6], acc_addr[base+6], acc_wdata[base+6]);
    end
    n_checks++; if (acc_cyc[base+6] !== at + 1) begin n_fail++; $display("[TB] FAIL pcw_issue_cycle: got %0d want %0d", acc_cyc[base+6], at + 1); end
    n_checks++; if (pat - acc_cyc[base+6] !== eng_n + 2) begin n_fail++; $display("[TB] FAIL pcw_done_latency: got %0d want %0d", pat - acc_cyc[base+6], eng_n + 2); end
    tick(10);
    n_checks++; if (pcdone_cnt - pd0 !== 1) begin n_fail++; $display("[TB] FAIL pcw_done_count: got %0d want 1", pcdone_cnt - pd0); end
    n_checks++; if (pc_pending !== 1'b0 || mem[7'h3A] !== 8'h55) begin n_fail++; $display("[TB] FAIL pcw_result: got pending %b mem %h want 0 55", pc_pending, mem[7'h3A]); end
  endtask

  task automatic test_error_and_pc_read();
    int base, at, pd0;
    bit ok;
    corrupt_en = 1'b1;
    corrupt_addr = 7'h21;
    base = acc_n;
    pulse_start();
    wait_sig(1, 400, ok, at);
    n_checks++; if (!ok) begin n_fail++; $display("[TB] FAIL err_timeout: init_err got 0 want 1"); end
    n_checks++; if (err_idx !== 2'd1 || init_done !== 1'b0) begin n_fail++; $display("[TB] FAIL err_idx: got idx %0d done %b want 1 0", err_idx, init_done); end
    tick(20);
    n_checks++; if (acc_n - base !== 4) begin n_fail++; $display("[TB] FAIL err_access_count: got %0d want 4", acc_n - base); end
    n_checks++; if (dut.state !== ERROR || init_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL err_state: got %0d busy %b want %0d 0", dut.state, init_busy, ERROR); end
    pd0 = pcdone_cnt;
    pc_req = 1'b1; pc_write = 1'b0; pc_addr = 7'h10; pc_wdata = 8'h00;
    tick();
    pc_req = 1'b0;
    tick();
    pc_req = 1'b1; pc_write = 1'b1; pc_addr = 7'h11; pc_wdata = 8'hEE;
    tick();
    pc_req = 1'b0;
    wait_sig(2, 50, ok, at);
    n_checks++; if (!ok) begin n_fail++; $display("[TB] FAIL pcr_timeout: pc_done got 0 want 1"); end
    n_checks++; if (pc_rdata !== 8'hC3) begin n_fail++; $display("[TB] FAIL pcr_rdata: got %h want c3", pc_rdata); end
    tick(15);
    n_checks++; if (pcdone_cnt - pd0 !== 1) begin n_fail++; $display("[TB] FAIL pcr_done_count: got %0d want 1", pcdone_cnt - pd0); end
    n_checks++; if (acc_n - base !== 5) begin n_fail++; $display("[TB] FAIL pcr_access_count: got %0d want 5", acc_n - base); end
    n_checks++; if (dut.state !== ERROR || pc_pending !== 1'b0) begin n_fail++; $display("[TB] FAIL pcr_return: got state %0d pending %b want %0d 0", dut.state, pc_pending, ERROR); end
    corrupt_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    int base, sc, at;
    bit ok;
    eng_n = 20;
    pulse_start();
    wait_sig(3, 200, ok, at);
    n_checks++; if (!ok) begin n_fail++; $display("[TB] FAIL rmid_timeout: RD_BUSY not reached"); end
    rst = 1'b1;
    tick();
    n_checks++; if ({sif.spi_start, init_busy, pc_pending, pc_done} !== 4'h0) begin n_fail++; $display("[TB] FAIL rmid_ctrl: got %b want 0000", {sif.spi_start, init_busy, pc_pending, pc_done}); end
    n_checks++; if ({tbl_idx, err_idx, pc_rdata} !== 12'h0) begin n_fail++; $display("[TB] FAIL rmid_regs: got %h want 0", {tbl_idx, err_idx, pc_rdata}); end
    n_checks++; if ({sif.spi_mode, sif.spi_addr, sif.spi_wdata} !== 16'h0) begin n_fail++; $display("[TB] FAIL rmid_bus: got %h want 0", {sif.spi_mode, sif.spi_addr, sif.spi_wdata}); end
    n_checks++; if (dut.state !== IDLE) begin n_fail++; $display("[TB] FAIL rmid_state: got %0d want %0d", dut.state, IDLE); end
    rst = 1'b0;
    tick();
    base = acc_n;
    sc = cyc;
    pulse_start();
    wait_sig(0, 600, ok, at);
    n_checks++; if (!ok) begin n_fail++; $display("[TB] FAIL rmid_done_timeout: init_done got 0 want 1"); end
    n_checks++; if (acc_addr[base] !== 7'h20 || acc_mode[base] !== 1'b1) begin n_fail++; $display("[TB] FAIL rmid_first_access: got addr %h mode %b want 20 1", acc_addr[base], acc_mode[base]); end
    n_checks++; if (acc_cyc[base] !== acc_rise[base] + 1 || acc_cyc[base] - sc <= RST_WAIT + 1) begin n_fail++; $display("[TB] FAIL rmid_wait_ready: got issue %0d rise %0d start %0d want issue=rise+1 and later than %0d", acc_cyc[base], acc_rise[base], sc, sc + RST_WAIT + 1); end
    n_checks++; if (acc_n - base !== 6) begin n_fail++; $display("[TB] FAIL rmid_access_count: got %0d want 6", acc_n - base); end
    eng_n = 5;
  endtask

  task automatic test_start_during_wait();
    int base, sc, at;
    bit ok;
    base = acc_n;
    sc = cyc;
    pulse_start();
    tick();
    pulse_start();
    wait_sig(0, 400, ok, at);
    n_checks++; if (!ok) begin n_fail++; $display("[TB] FAIL ign_timeout: init_done got 0 want 1"); end
    n_checks++; if (at - sc !== 50) begin n_fail++; $display("[TB] FAIL ign_total_cycles: got %0d want 50", at - sc); end
    n_checks++; if (acc_cyc[base] - sc !== RST_WAIT + 1) begin n_fail++; $display("[TB] FAIL ign_first_start: got %0d want %0d", acc_cyc[base] - sc, RST_WAIT + 1); end
    tick(10);
    n_checks++; if (acc_n - base !== 6) begin n_fail++; $display("[TB] FAIL ign_access_count: got %0d want 6", acc_n - base); end
    n_checks++; if (dbl_cnt !== 0) begin n_fail++; $display("[TB] FAIL back_to_back_start: got %0d want 0", dbl_cnt); end
  endtask

  initial begin
    rst = 1'b1;
    init_start = 1'b0;
    pc_req = 1'b0;
    pc_write = 1'b0;
    pc_addr = '0;
    pc_wdata = '0;
    tick(3);
    test_reset();
    rst = 1'b0;
    tick(2);
    test_sequence();
    tick(3);
    test_pc_during_seq();
    tick(3);
    test_error_and_pc_read();
    tick(3);
    test_reset_mid();
    tick(3);
    test_start_during_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
